hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage in-order core. Generates the per-stage `stall`/`flush` controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers. It covers three hazard classes:
- load-use data hazards;
- multi-cycle EX operations (mul/div) that hold the EX stage for a fixed number of cycles;
- branch/jump redirects resolved in EX.

It also keeps saturating stall and flush performance counters.

## Interface
- `MC_LAT`, 4: total EX-stage occupancy in cycles of a multi-cycle op; legal range ≥ 2.
- `CW`, 32: width of the performance counters.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  global pipeline enable/start.
- `id_valid`  in  1  ID stage holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5 each  ID source register indices.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  source actually read.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_wr`  in  1  EX instruction writes `ex_rd`.
- `ex_rd`  in  5  EX destination index.
- `ex_is_mc`  in  1  EX instruction is multi-cycle.
- `ex_redirect`  in  1  EX resolved a taken branch/jump or mispredict.
- `pc_stall`  out  1  hold PC.
- `ifid_stall`, `ifid_flush`  out  1 each  IF/ID control.
- `idex_stall`, `idex_flush`  out  1 each  ID/EX control.
- `exmem_flush`  out  1  insert bubble into EX/MEM.
- `mc_busy`  out  1  multi-cycle op stalling.
- `stall_cnt`  out  CW  cycles with `pc_stall`=1.
- `flush_cnt`  out  CW  redirect events.

## Operation
- State machine with two states:
  - RUN: normal flow, hazard detection is combinational on inputs.
  - MC_WAIT: multi-cycle op holds EX. Internal down-counter `cnt`, width clog2(MC_LAT).
- Qualifiers, all gated by `en`:
  - `redir` = `ex_valid & ex_redirect`.
  - `mc_hit` = `ex_valid & ex_is_mc`.
  - `lu_hit` = `ex_valid & ex_is_load & ex_wr & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- RUN priority is `redir` > `mc_hit` > `lu_hit`:
  - `redir`: `ifid_flush`=1, `idex_flush`=1, all stalls 0. Stay in RUN. `flush_cnt`++.
  - `mc_hit`: `pc_stall`=`ifid_stall`=`idex_stall`=1, `exmem_flush`=1, `mc_busy`=1. Load `cnt`=MC_LAT-2, go to MC_WAIT.
  - `lu_hit`: `pc_stall`=`ifid_stall`=1, `idex_flush`=1 (one bubble). Stay in RUN.
  - none: all outputs 0.
- MC_WAIT:
  - `cnt`≠0: same outputs as the `mc_hit` cycle, `cnt`--.
  - `cnt`==0: all outputs 0, go to RUN. This is the release cycle: the op advances to EX/MEM at its end, and `ex_is_mc` is not re-evaluated in this cycle.
  - All hazard inputs are ignored in MC_WAIT.
- Simultaneous `ex_redirect` and `ex_is_mc` on one instruction is illegal. Redirect wins and MC_WAIT is not entered.
- `en`=0: all outputs 0, next state RUN, `cnt`=0, counters hold. Dropping `en` mid-MC_WAIT aborts the wait.
- Counters:
  - `stall_cnt` increments every cycle `pc_stall`=1.
  - `flush_cnt` increments once per `redir` cycle.
  - Both saturate at 2^CW-1.

## Timing
- Outputs are Mealy: combinational from the registered state/`cnt` and the current inputs. No added latency, and they are valid in the same cycle as the hazard.
- Reset, sampled on the rising edge while `rst`=1:
  - state=RUN, `cnt`=0, `stall_cnt`=0, `flush_cnt`=0.
  - While `rst`=1, every control output and `mc_busy` is forced 0.
  - Reset mid-MC_WAIT returns to RUN at the next edge.
- Multi-cycle op entering EX in cycle t:
  - Stalls asserted in cycles t … t+MC_LAT-2, i.e. MC_LAT-1 cycles.
  - Release in cycle t+MC_LAT-1.
  - MC_LAT=2: one stall cycle, then release.
- Load-use hazard: exactly one stall cycle. In the next cycle the load is in MEM and `lu_hit` drops naturally.
- Redirect: a single flush cycle kills the two younger instructions (IF→IF/ID, ID→ID/EX). PC loads the target in the same cycle (`pc_stall`=0).
- Counter updates are visible the cycle after the triggering event.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `ex_redirect`=1 -> all outputs 0, `stall_cnt`=`flush_cnt`=0.
- Load-use: `ex_is_load`=1, `ex_wr`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 -> 1 cycle `pc_stall`=`ifid_stall`=`idex_flush`=1, `stall_cnt`=1. Repeat with `ex_rd`=0 -> no stall.
- Multi-cycle, MC_LAT=4: `ex_is_mc`=1 held -> `mc_busy`/stalls high for 3 cycles, 4th cycle all 0, `stall_cnt`=3. Rerun with MC_LAT=2 -> 1 stall cycle.
- Priority: `redir`, `mc_hit` and `lu_hit` together -> only `ifid_flush`=`idex_flush`=1, state stays RUN, `flush_cnt`=1.
- Abort: start an MC op, drop `en` in the 2nd stall cycle -> outputs 0 immediately, RUN next cycle. Same with `rst` instead -> counters cleared.
- Saturation, CW=4: 20 consecutive load-use stalls -> `stall_cnt` stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-stage stall/flush generation for the 5-stage in-order core
// (load-use, multi-cycle EX ops, EX-resolved redirects) plus saturating
// stall/flush performance counters.
// Ports: clk/rst (sync, active-high), en; ID operand info (id_*); EX info (ex_*);
// outputs pc_stall, ifid_*/idex_* stall/flush, exmem_flush, mc_busy, stall_cnt, flush_cnt.
// Outputs are Mealy (same-cycle); counters update the cycle after the event.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          id_valid,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic          ex_valid,
  input  logic          ex_is_load,
  input  logic          ex_wr,
  input  logic [4:0]    ex_rd,
  input  logic          ex_is_mc,
  input  logic          ex_redirect,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          ifid_flush,
  output logic          idex_stall,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          mc_busy,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Reset forces every control output low, same as en=0.
  logic act;
  logic redir, mc_hit, lu_hit;
  logic flush_ev;

  assign act    = en & ~rst;
  assign redir  = act & ex_valid & ex_redirect;
  assign mc_hit = act & ex_valid & ex_is_mc;
  assign lu_hit = act & ex_valid & ex_is_load & ex_wr & (ex_rd != 5'd0) & id_valid &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Redirects are only honoured in RUN; MC_WAIT ignores all hazard inputs.
  assign flush_ev = redir & (state == RUN);

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mc_busy     = 1'b0;
    if (act) begin
      if (state == MC_WAIT) begin
        // cnt==0 is the release cycle: everything low so the op moves on.
        if (cnt != '0) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_flush = 1'b1;
          mc_busy     = 1'b1;
        end
      end else if (redir) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (mc_hit) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_flush = 1'b1;
        mc_busy     = 1'b1;
      end else if (lu_hit) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!en) begin
      // Dropping en aborts any multi-cycle wait.
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!redir && mc_hit) begin
            state <= MC_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        MC_WAIT: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CW{1'b1}})) stall_cnt <= stall_cnt + CW'(1);
      if (flush_ev && (flush_cnt != {CW{1'b1}})) flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share the stimulus:
// a (MC_LAT=4, CW=32), b (MC_LAT=2, CW=32), c (MC_LAT=4, CW=4).
// Control outputs are packed as {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, mc_busy}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_is_load, ex_wr, ex_is_mc, ex_redirect;

  logic a_pc, a_ifs, a_iff, a_ids, a_idf, a_exf, a_busy;
  logic b_pc, b_ifs, b_iff, b_ids, b_idf, b_exf, b_busy;
  logic c_pc, c_ifs, c_iff, c_ids, c_idf, c_exf, c_busy;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [3:0]  c_scnt, c_fcnt;
  logic [6:0]  a_o, b_o, c_o;

  assign a_o = {a_pc, a_ifs, a_iff, a_ids, a_idf, a_exf, a_busy};
  assign b_o = {b_pc, b_ifs, b_iff, b_ids, b_idf, b_exf, b_busy};
  assign c_o = {c_pc, c_ifs, c_iff, c_ids, c_idf, c_exf, c_busy};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_MC   = 7'b1101011;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_RED  = 7'b0010100;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LAT(4), .CW(32)) dut_a (
    .clk(clk), .rst(rst), .en(en), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_is_mc(ex_is_mc),
    .ex_redirect(ex_redirect), .pc_stall(a_pc), .ifid_stall(a_ifs), .ifid_flush(a_iff),
    .idex_stall(a_ids), .idex_flush(a_idf), .exmem_flush(a_exf), .mc_busy(a_busy),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_ctrl #(.MC_LAT(2), .CW(32)) dut_b (
    .clk(clk), .rst(rst), .en(en), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_is_mc(ex_is_mc),
    .ex_redirect(ex_redirect), .pc_stall(b_pc), .ifid_stall(b_ifs), .ifid_flush(b_iff),
    .idex_stall(b_ids), .idex_flush(b_idf), .exmem_flush(b_exf), .mc_busy(b_busy),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  hazard_ctrl #(.MC_LAT(4), .CW(4)) dut_c (
    .clk(clk), .rst(rst), .en(en), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_is_mc(ex_is_mc),
    .ex_redirect(ex_redirect), .pc_stall(c_pc), .ifid_stall(c_ifs), .ifid_flush(c_iff),
    .idex_stall(c_ids), .idex_flush(c_idf), .exmem_flush(c_exf), .mc_busy(c_busy),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  // Advance one cycle; inputs change 1 time unit after the rising edge,
  // outputs are sampled 4 units later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    en = 1'b1; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    ex_wr = 1'b0; ex_rd = 5'd0; ex_is_mc = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_wr = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd5; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1;
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL reset_out_c1: got %b want %b", a_o, O_NONE); end
    tick();
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL reset_out_c2: got %b want %b", a_o, O_NONE); end
    compared++; if (a_scnt !== 32'd0) begin mismatched++; $display("FAIL reset_stall_cnt: got %0d want 0", a_scnt); end
    compared++; if (a_fcnt !== 32'd0) begin mismatched++; $display("FAIL reset_flush_cnt: got %0d want 0", a_fcnt); end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5);
    settle();
    compared++; if (a_o !== O_LU) begin mismatched++; $display("FAIL lu_hit: got %b want %b", a_o, O_LU); end
    tick();
    clear_inputs();  // load has moved to MEM
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL lu_after: got %b want %b", a_o, O_NONE); end
    compared++; if (a_scnt !== 32'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d want 1", a_scnt); end
    set_load_use(5'd0);
    id_rs1 = 5'd0;  // x0 source must never hazard
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL lu_x0: got %b want %b", a_o, O_NONE); end
    tick();
    set_load_use(5'd5);
    id_uses_rs2 = 1'b0;  // rs2 matches but is not read
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL lu_unused_src: got %b want %b", a_o, O_NONE); end
    tick();
    clear_inputs();
    settle();
    compared++; if (a_scnt !== 32'd1) begin mismatched++; $display("FAIL lu_stall_cnt_hold: got %0d want 1", a_scnt); end
  endtask

  task automatic test_multicycle();
    apply_reset();
    ex_valid = 1'b1; ex_is_mc = 1'b1;
    settle();  // t
    compared++; if (a_o !== O_MC) begin mismatched++; $display("FAIL mc4_t0: got %b want %b", a_o, O_MC); end
    compared++; if (b_o !== O_MC) begin mismatched++; $display("FAIL mc2_t0: got %b want %b", b_o, O_MC); end
    tick();
    ex_redirect = 1'b1;  // must be ignored while waiting
    settle();  // t+1
    compared++; if (a_o !== O_MC) begin mismatched++; $display("FAIL mc4_t1: got %b want %b", a_o, O_MC); end
    compared++; if (b_o !== O_NONE) begin mismatched++; $display("FAIL mc2_release: got %b want %b", b_o, O_NONE); end
    tick();
    ex_redirect = 1'b0;
    settle();  // t+2: b sees a fresh mc op
    compared++; if (a_o !== O_MC) begin mismatched++; $display("FAIL mc4_t2: got %b want %b", a_o, O_MC); end
    compared++; if (b_o !== O_MC) begin mismatched++; $display("FAIL mc2_t2: got %b want %b", b_o, O_MC); end
    tick();
    settle();  // t+3
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL mc4_release: got %b want %b", a_o, O_NONE); end
    compared++; if (b_o !== O_NONE) begin mismatched++; $display("FAIL mc2_release2: got %b want %b", b_o, O_NONE); end
    tick();
    clear_inputs();
    settle();
    compared++; if (a_scnt !== 32'd3) begin mismatched++; $display("FAIL mc4_stall_cnt: got %0d want 3", a_scnt); end
    compared++; if (b_scnt !== 32'd2) begin mismatched++; $display("FAIL mc2_stall_cnt: got %0d want 2", b_scnt); end
    compared++; if (a_fcnt !== 32'd0) begin mismatched++; $display("FAIL mc4_flush_cnt: got %0d want 0", a_fcnt); end
  endtask

  task automatic test_priority();
    apply_reset();
    set_load_use(5'd5);
    ex_is_mc = 1'b1; ex_redirect = 1'b1;
    settle();
    compared++; if (a_o !== O_RED) begin mismatched++; $display("FAIL prio_out: got %b want %b", a_o, O_RED); end
    tick();
    clear_inputs();
    settle();  // MC_WAIT would show mc_busy here
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL prio_stay_run: got %b want %b", a_o, O_NONE); end
    compared++; if (a_fcnt !== 32'd1) begin mismatched++; $display("FAIL prio_flush_cnt: got %0d want 1", a_fcnt); end
    compared++; if (a_scnt !== 32'd0) begin mismatched++; $display("FAIL prio_stall_cnt: got %0d want 0", a_scnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ex_valid = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      compared++; if (a_o !== O_RED) begin mismatched++; $display("FAIL b2b_redir_%0d: got %b want %b", i, a_o, O_RED); end
      tick();
    end
    clear_inputs();
    settle();
    compared++; if (a_fcnt !== 32'd3) begin mismatched++; $display("FAIL b2b_flush_cnt: got %0d want 3", a_fcnt); end
  endtask

  task automatic test_abort();
    apply_reset();
    ex_valid = 1'b1; ex_is_mc = 1'b1;
    settle();
    tick();
    en = 1'b0;  // 2nd stall cycle
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL abort_en_now: got %b want %b", a_o, O_NONE); end
    tick();
    clear_inputs();
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL abort_en_run: got %b want %b", a_o, O_NONE); end
    compared++; if (a_scnt !== 32'd1) begin mismatched++; $display("FAIL abort_en_cnt: got %0d want 1", a_scnt); end
    tick();
    ex_valid = 1'b1; ex_is_mc = 1'b1;
    settle();
    tick();
    rst = 1'b1;
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL abort_rst_now: got %b want %b", a_o, O_NONE); end
    tick();
    rst = 1'b0;
    clear_inputs();
    settle();
    compared++; if (a_o !== O_NONE) begin mismatched++; $display("FAIL abort_rst_run: got %b want %b", a_o, O_NONE); end
    compared++; if (a_scnt !== 32'd0) begin mismatched++; $display("FAIL abort_rst_cnt: got %0d want 0", a_scnt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_load_use(5'd5);
    for (int i = 0; i < 20; i++) tick();
    clear_inputs();
    settle();
    compared++; if (c_scnt !== 4'd15) begin mismatched++; $display("FAIL sat_cw4: got %0d want 15", c_scnt); end
    compared++; if (a_scnt !== 32'd20) begin mismatched++; $display("FAIL sat_cw32: got %0d want 20", a_scnt); end
    tick();
    set_load_use(5'd5);
    settle();
    compared++; if (c_o !== O_LU) begin mismatched++; $display("FAIL sat_still_stalls: got %b want %b", c_o, O_LU); end
    tick();
    clear_inputs();
    settle();
    compared++; if (c_scnt !== 4'd15) begin mismatched++; $display("FAIL sat_hold: got %0d want 15", c_scnt); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_multicycle();
    test_priority();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
